// File: rtl/inport_debounce_capture.sv
// inport_debounce_capture
// Turns the board switches and a bouncy "load" button into the 32-bit INPORTin word.
// Raw inputs are double-flopped into the clk domain. A four-state FSM debounces the
// button. On each accepted press the synchronised switch value is extended to 32 bits
// and latched, and new_data pulses for one cycle.

module inport_debounce_capture #(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit SIGN_EXT        = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw,
    input  logic                btn,
    output logic [31:0]         inport_q,
    output logic                new_data,
    output logic                busy
);

    // Keep the counter at least one bit wide for the smallest legal debounce length.
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    logic                btn_meta_reg;
    logic                btn_s_reg;
    logic [SW_WIDTH-1:0] sw_meta_reg;
    logic [SW_WIDTH-1:0] sw_s_reg;

    logic [1:0]          state_reg;
    logic [1:0]          state_next;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;
    logic                capture;

    logic [31:0]         sw_ext;
    logic [31:0]         inport_reg;
    logic                new_data_reg;
    logic                busy_reg;

    // Two-flop synchronisers for the button and every switch bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_reg <= 1'b0;
            btn_s_reg    <= 1'b0;
            sw_meta_reg  <= '0;
            sw_s_reg     <= '0;
        end else begin
            btn_meta_reg <= btn;
            btn_s_reg    <= btn_meta_reg;
            sw_meta_reg  <= sw;
            sw_s_reg     <= sw_meta_reg;
        end
    end

    // Widen the synchronised switches to 32 bits; a full-width bus needs no padding.
    generate
        if (SW_WIDTH >= 32) begin : g_ext_full
            assign sw_ext = sw_s_reg[31:0];
        end else if (SIGN_EXT) begin : g_ext_sign
            assign sw_ext = {{(32 - SW_WIDTH){sw_s_reg[SW_WIDTH-1]}}, sw_s_reg};
        end else begin : g_ext_zero
            assign sw_ext = {{(32 - SW_WIDTH){1'b0}}, sw_s_reg};
        end
    endgenerate

    // Debounce FSM next-state logic; the counter restarts on every state entry.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (btn_s_reg) begin
                    state_next = PRESS_DB;
                    cnt_next   = '0;
                end
            end
            PRESS_DB: begin
                if (!btn_s_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    capture    = 1'b1;
                end else begin
                    cnt_next   = cnt_reg + CW'(1);
                end
            end
            HELD: begin
                if (!btn_s_reg) begin
                    state_next = RELEASE_DB;
                    cnt_next   = '0;
                end
            end
            default: begin
                if (btn_s_reg) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    // State, counter and busy flag; busy tracks the state it is registered with.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next != IDLE);
        end
    end

    // Capture register and its one-cycle new_data strobe, updated on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inport_reg   <= 32'h0;
            new_data_reg <= 1'b0;
        end else begin
            new_data_reg <= capture;
            if (capture) begin
                inport_reg <= sw_ext;
            end
        end
    end

    assign inport_q = inport_reg;
    assign new_data = new_data_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_inport_debounce_capture.sv
// Bench for inport_debounce_capture: two instances (zero- and sign-extending) share
// the stimulus. A run-length model of the debounce rules pushes expected captures into
// per-instance queues; a negedge monitor pops and compares whenever new_data is seen.

module tb_inport_debounce_capture;

    localparam int D  = 4;
    localparam int SW = 8;

    typedef struct {
        logic [31:0] w;
        int          c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] sw;
    logic          btn;
    logic [31:0]   inport_q0, inport_q1;
    logic          new_data0, new_data1;
    logic          busy0, busy1;

    int compared   = 0;
    int mismatched = 0;
    int nd0_count  = 0;

    // model state
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    logic        bh0, bh1;
    logic [SW-1:0] sh0, sh1;
    bit          held;
    int          hi_run, lo_run;
    logic [31:0] val0, val1;

    always #5 clk = ~clk;

    inport_debounce_capture #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(D), .SIGN_EXT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .sw(sw), .btn(btn),
        .inport_q(inport_q0), .new_data(new_data0), .busy(busy0));

    inport_debounce_capture #(.SW_WIDTH(SW), .DEBOUNCE_CYCLES(D), .SIGN_EXT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .sw(sw), .btn(btn),
        .inport_q(inport_q1), .new_data(new_data1), .busy(busy1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a press is accepted after D+1 consecutive synchronised-high
    // samples while idle; the button counts as released after D+1 consecutive lows.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bh0 = 1'b0; bh1 = 1'b0; sh0 = '0; sh1 = '0;
            held = 1'b0; hi_run = 0; lo_run = 0;
            val0 = 32'h0; val1 = 32'h0;
            q0.delete(); q1.delete();
        end else begin
            logic          b;
            logic [SW-1:0] s;
            cyc++;
            b = bh1; s = sh1;
            bh1 = bh0; bh0 = btn;
            sh1 = sh0; sh0 = sw;
            if (!held) begin
                if (b) begin
                    hi_run++;
                    if (hi_run == D + 1) begin
                        val0 = {24'h0, s};
                        val1 = {{24{s[SW-1]}}, s};
                        q0.push_back('{w: val0, c: cyc});
                        q1.push_back('{w: val1, c: cyc});
                        held = 1'b1; hi_run = 0; lo_run = 0;
                    end
                end else begin
                    hi_run = 0;
                end
            end else begin
                if (!b) begin
                    lo_run++;
                    if (lo_run == D + 1) begin
                        held = 1'b0; lo_run = 0;
                    end
                end else begin
                    lo_run = 0;
                end
            end
        end
    end

    // Monitor: per-cycle state checks plus scoreboard pops on each new_data.
    always @(negedge clk) begin
        logic exp_nd0, exp_nd1, exp_busy;
        exp_busy = held || (hi_run > 0);
        check("busy0", {31'h0, busy0}, {31'h0, exp_busy});
        check("busy1", {31'h0, busy1}, {31'h0, exp_busy});
        check("inport_q0", inport_q0, val0);
        check("inport_q1", inport_q1, val1);
        exp_nd0 = (q0.size() > 0) && (q0[0].c == cyc);
        exp_nd1 = (q1.size() > 0) && (q1[0].c == cyc);
        if (new_data0) nd0_count++;
        if (new_data0 || exp_nd0) begin
            check("new_data0", {31'h0, new_data0}, {31'h0, exp_nd0});
            if (q0.size() > 0) begin
                exp_t e;
                e = q0.pop_front();
                if (new_data0) check("capture0", inport_q0, e.w);
            end
        end
        if (new_data1 || exp_nd1) begin
            check("new_data1", {31'h0, new_data1}, {31'h0, exp_nd1});
            if (q1.size() > 0) begin
                exp_t e;
                e = q1.pop_front();
                if (new_data1) check("capture1", inport_q1, e.w);
            end
        end
    end

    task automatic hold(input logic b, input logic [SW-1:0] s, input int n);
        btn = b;
        sw  = s;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        int base;
        reset = 1'b0; btn = 1'b0; sw = '0;
        @(posedge clk); #2;

        // 1: reset held with button pressed
        hold(1'b1, 8'hFF, 10);
        check("rst_pulses", nd0_count, 0);
        check("rst_q0", inport_q0, 32'h0);
        check("rst_busy", {31'h0, busy0}, 32'h0);
        reset = 1'b1;
        hold(1'b1, 8'hFF, 20);
        check("post_rst_pulses", nd0_count, 1);
        check("post_rst_q1", inport_q1, 32'hFFFFFFFF);
        hold(1'b0, 8'hFF, 10);

        // 2: zero-extend
        base = nd0_count;
        hold(1'b1, 8'hA5, 20);
        hold(1'b0, 8'hA5, 10);
        check("zext_q0", inport_q0, 32'h000000A5);
        check("zext_pulses", nd0_count - base, 1);

        // 3: sign-extend, negative then positive
        hold(1'b1, 8'h85, 12);
        hold(1'b0, 8'h85, 10);
        check("sext_neg_q1", inport_q1, 32'hFFFFFF85);
        hold(1'b1, 8'h12, 12);
        hold(1'b0, 8'h12, 10);
        check("sext_pos_q1", inport_q1, 32'h00000012);

        // 4: bouncing press
        base = nd0_count;
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, 8'h3C, 2);
            hold(1'b0, 8'h3C, 1);
        end
        check("bounce_pulses", nd0_count - base, 0);
        hold(1'b1, 8'h3C, 12);
        check("settle_pulses", nd0_count - base, 1);
        hold(1'b0, 8'h3C, 10);

        // 5: long hold with switch change mid-hold
        base = nd0_count;
        hold(1'b1, 8'h01, 50);
        hold(1'b1, 8'h02, 50);
        check("longhold_q0", inport_q0, 32'h00000001);
        hold(1'b0, 8'h02, 10);
        hold(1'b1, 8'h02, 12);
        check("repress_q0", inport_q0, 32'h00000002);
        check("longhold_pulses", nd0_count - base, 2);
        hold(1'b0, 8'h02, 10);

        // 6: reset while in PRESS_DB with cnt=2
        base = nd0_count;
        hold(1'b1, 8'h33, 5);
        reset = 1'b0;
        hold(1'b1, 8'h33, 3);
        check("midrst_busy", {31'h0, busy0}, 32'h0);
        check("midrst_q0", inport_q0, 32'h0);
        check("midrst_pulses", nd0_count - base, 0);
        reset = 1'b1;
        hold(1'b0, 8'h33, 6);

        // 6b: short release bounces return to HELD without capture
        hold(1'b1, 8'h44, 12);
        base = nd0_count;
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 8'h55, 2);
            hold(1'b1, 8'h55, 2);
        end
        check("relbounce_pulses", nd0_count - base, 0);
        check("relbounce_busy", {31'h0, busy0}, 32'h1);
        check("relbounce_q0", inport_q0, 32'h00000044);
        hold(1'b0, 8'h55, 10);

        // 7: random button/switch activity
        for (int i = 0; i < 400; i++) begin
            hold(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 8));
        end
        hold(1'b0, 8'h00, 12);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
